// File: rtl/nand_pkg.sv
// Shared definitions for the NAND flash responder: bus commands, FSM states
// and the classification of WEN latch events.
package nand_pkg;

    localparam logic [7:0] CMD_READ0   = 8'h00;
    localparam logic [7:0] CMD_READ1   = 8'h01;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_CONFIRM = 8'h10;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_LOAD,
        ST_READ,
        ST_PADDR0,
        ST_PADDR1,
        ST_PADDR2,
        ST_PDATA,
        ST_PROG,
        ST_RSTB
    } nand_state_t;

    typedef enum logic [1:0] {
        LAT_NONE,
        LAT_CMD,
        LAT_ADDR,
        LAT_DATA
    } latch_t;

    // Where a command latched from an idle-like state leads; unknown commands go to 'other'.
    function automatic nand_state_t cmd_next(input logic [7:0] cmd, input nand_state_t other);
        case (cmd)
            CMD_READ0, CMD_READ1: return ST_ADDR0;
            CMD_PROG:             return ST_PADDR0;
            CMD_RESET:            return ST_RSTB;
            default:              return other;
        endcase
    endfunction

    function automatic logic is_busy(input nand_state_t s);
        return s inside {ST_LOAD, ST_PROG, ST_RSTB};
    endfunction

endpackage

// File: rtl/nand_flash_responder_edge_sync.sv
// Registers the controller-side bus once and turns WEN/REN transitions into
// single-cycle latch events and read strobes.
module nand_edge_sync import nand_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       cle,
    input  logic       ale,
    input  logic       wen,
    input  logic       ren,
    input  logic [7:0] io_in,
    output latch_t     lat_type,
    output logic [7:0] lat_byte,
    output logic       rd_strobe,
    output logic       ren_high
);

    logic       cle_q, ale_q, wen_q, ren_q, wen_p, ren_p;
    logic [7:0] io_q;
    logic       wen_rise;

    // Input register stage plus previous strobe levels; strobes idle high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cle_q <= 1'b0;
            ale_q <= 1'b0;
            wen_q <= 1'b1;
            ren_q <= 1'b1;
            wen_p <= 1'b1;
            ren_p <= 1'b1;
            io_q  <= 8'h00;
        end else begin
            cle_q <= cle;
            ale_q <= ale;
            wen_q <= wen;
            ren_q <= ren;
            wen_p <= wen_q;
            ren_p <= ren_q;
            io_q  <= io_in;
        end
    end

    // Classify the WEN rising edge; a coincident REN fall loses to it
    always_comb begin
        wen_rise = wen_q & ~wen_p;
        lat_type = LAT_NONE;
        if (wen_rise) begin
            case ({cle_q, ale_q})
                2'b10:   lat_type = LAT_CMD;
                2'b01:   lat_type = LAT_ADDR;
                2'b00:   lat_type = LAT_DATA;
                default: lat_type = LAT_NONE;
            endcase
        end
        rd_strobe = ren_p & ~ren_q & ~wen_rise;
    end

    assign lat_byte = io_q;
    assign ren_high = ren_q;

endmodule

// File: rtl/nand_flash_responder.sv
// Device-side NAND flash model: decodes command/address/data latches, moves
// pages between the internal page buffer and an external backing array, and
// drives F_RB busy during page load, program and reset.
//
//   state     | meaning
//   ST_IDLE   | ready, waiting for a command
//   ST_ADDR0  | read: column[7:0] address cycle
//   ST_ADDR1  | read: row[7:0] address cycle
//   ST_ADDR2  | read: row[15:8] address cycle
//   ST_LOAD   | busy: array page -> buffer
//   ST_READ   | serving buffer bytes on REN strobes
//   ST_PADDR0 | program: column[7:0], buffer preset to FFh runs meanwhile
//   ST_PADDR1 | program: row[7:0]
//   ST_PADDR2 | program: row[15:8]
//   ST_PDATA  | program: data bytes into buffer
//   ST_PROG   | busy: buffer -> array page
//   ST_RSTB   | busy: reset command recovery
//
// The FFh preset of the page buffer takes PAGE_SIZE cycles after 80h; the
// controller is expected to leave at least that long before data entry.
module nand_flash_responder import nand_pkg::*; #(
    parameter int PAGE_SIZE = 512,
    parameter int COL_W     = 9,
    parameter int ROW_W     = 16,
    parameter int T_R       = 600,
    parameter int T_PROG    = 700,
    parameter int T_RST     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   F_CLE,
    input  logic                   F_ALE,
    input  logic                   F_WEN,
    input  logic                   F_REN,
    output logic                   F_RB,
    input  logic [7:0]             IO_in,
    output logic [7:0]             IO_out,
    output logic                   IO_oe,
    output logic [ROW_W+COL_W-1:0] arr_addr,
    output logic                   arr_re,
    input  logic [7:0]             arr_rdata,
    output logic                   arr_we,
    output logic [7:0]             arr_wdata
);

    localparam int CNT_W = COL_W + 1;
    localparam int TMR_W = 16;

    nand_state_t      state, state_next;
    latch_t           lat_type;
    logic [7:0]       lat_byte;
    logic             rd_strobe, ren_high;
    logic             lat_cmd, lat_addr, lat_data, entering;

    logic [COL_W-1:0] column;
    logic [ROW_W-1:0] row;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] xfer_cnt;
    logic [COL_W-1:0] preset_cnt;
    logic             preset_busy, preset_wr;
    logic             fill_pend;
    logic [COL_W-1:0] fill_idx;

    logic [7:0]       page_buf [PAGE_SIZE];
    logic             buf_we;
    logic [COL_W-1:0] buf_waddr;
    logic [7:0]       buf_wdata;

    nand_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .cle       (F_CLE),
        .ale       (F_ALE),
        .wen       (F_WEN),
        .ren       (F_REN),
        .io_in     (IO_in),
        .lat_type  (lat_type),
        .lat_byte  (lat_byte),
        .rd_strobe (rd_strobe),
        .ren_high  (ren_high)
    );

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
        return (c == COL_W'(PAGE_SIZE - 1)) ? '0 : c + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state decode; busy states only watch their timer
    always_comb begin
        lat_cmd    = (lat_type == LAT_CMD);
        lat_addr   = (lat_type == LAT_ADDR);
        lat_data   = (lat_type == LAT_DATA);
        state_next = state;
        case (state)
            ST_IDLE:   if (lat_cmd) state_next = cmd_next(lat_byte, ST_IDLE);
            ST_READ:   if (lat_cmd) state_next = cmd_next(lat_byte, ST_IDLE);
            ST_ADDR0:  if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_ADDR1;
            ST_ADDR1:  if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_ADDR2;
            ST_ADDR2:  if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_LOAD;
            ST_PADDR0: if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_PADDR1;
            ST_PADDR1: if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_PADDR2;
            ST_PADDR2: if (lat_cmd && lat_byte == CMD_RESET) state_next = ST_RSTB;
                       else if (lat_addr) state_next = ST_PDATA;
            ST_PDATA:  if (lat_cmd) state_next = (lat_byte == CMD_CONFIRM) ? ST_PROG
                                                 : cmd_next(lat_byte, ST_IDLE);
            ST_LOAD:   if (timer == '0) state_next = ST_READ;
            ST_PROG,
            ST_RSTB:   if (timer == '0) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        entering = (state_next != state);
    end

    // Page buffer write port: array fill, then data latch, then FFh preset
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = fill_idx;
        buf_wdata = arr_rdata;
        preset_wr = 1'b0;
        if (fill_pend) begin
            buf_we = 1'b1;
        end else if (state == ST_PDATA && lat_data) begin
            buf_we    = 1'b1;
            buf_waddr = column;
            buf_wdata = lat_byte;
        end else if (preset_busy) begin
            buf_we    = 1'b1;
            buf_waddr = preset_cnt;
            buf_wdata = 8'hFF;
            preset_wr = 1'b1;
        end
    end

    // Page buffer storage, contents survive reset
    always_ff @(posedge clk) begin
        if (buf_we) page_buf[buf_waddr] <= buf_wdata;
    end

    // Datapath: addresses, busy timer, array transfers and read-out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            column      <= '0;
            row         <= '0;
            timer       <= '0;
            xfer_cnt    <= '0;
            preset_cnt  <= '0;
            preset_busy <= 1'b0;
            fill_pend   <= 1'b0;
            fill_idx    <= '0;
            F_RB        <= 1'b1;
            IO_out      <= 8'h00;
            IO_oe       <= 1'b0;
            arr_re      <= 1'b0;
            arr_we      <= 1'b0;
            arr_addr    <= '0;
            arr_wdata   <= 8'h00;
        end else begin
            F_RB      <= !is_busy(state_next);
            arr_re    <= 1'b0;
            arr_we    <= 1'b0;
            fill_pend <= arr_re;
            fill_idx  <= arr_addr[COL_W-1:0];

            if (entering && state_next == ST_LOAD)      timer <= TMR_W'(T_R - 1);
            else if (entering && state_next == ST_PROG) timer <= TMR_W'(T_PROG - 1);
            else if (entering && state_next == ST_RSTB) timer <= TMR_W'(T_RST - 1);
            else if (timer != '0)                       timer <= timer - 1'b1;

            if (entering && state_next == ST_RSTB) begin
                column <= '0;
                row    <= '0;
            end else begin
                if (entering && state_next == ST_ADDR0)  column[COL_W-1] <= lat_byte[0];
                if (entering && state_next == ST_PADDR0) column[COL_W-1] <= 1'b0;
                if (lat_addr && (state == ST_ADDR0 || state == ST_PADDR0)) column[7:0] <= lat_byte;
                if (lat_addr && (state == ST_ADDR1 || state == ST_PADDR1)) row[7:0] <= lat_byte;
                if (lat_addr && (state == ST_ADDR2 || state == ST_PADDR2))
                    row[ROW_W-1:8] <= lat_byte[ROW_W-9:0];
                if ((state == ST_PDATA && lat_data) || (state == ST_READ && rd_strobe))
                    column <= col_inc(column);
            end

            if (entering && (state_next == ST_LOAD || state_next == ST_PROG)) begin
                xfer_cnt <= '0;
            end else if ((state == ST_LOAD || state == ST_PROG) && xfer_cnt < CNT_W'(PAGE_SIZE)) begin
                xfer_cnt <= xfer_cnt + 1'b1;
                arr_addr <= {row, xfer_cnt[COL_W-1:0]};
                if (state == ST_LOAD) begin
                    arr_re <= 1'b1;
                end else begin
                    arr_we    <= 1'b1;
                    arr_wdata <= page_buf[xfer_cnt[COL_W-1:0]];
                end
            end

            // Preset stops early if the program sequence is left before it completes
            if (entering && state_next == ST_PADDR0) begin
                preset_busy <= 1'b1;
                preset_cnt  <= '0;
            end else if (preset_busy) begin
                if (!(state_next inside {ST_PADDR0, ST_PADDR1, ST_PADDR2, ST_PDATA})) begin
                    preset_busy <= 1'b0;
                end else if (preset_wr) begin
                    preset_cnt <= preset_cnt + 1'b1;
                    if (preset_cnt == COL_W'(PAGE_SIZE - 1)) preset_busy <= 1'b0;
                end
            end

            if (state == ST_READ && rd_strobe) begin
                IO_out <= page_buf[column];
                IO_oe  <= 1'b1;
            end else if (ren_high) begin
                IO_oe <= 1'b0;
            end
        end
    end

endmodule
